// File: rtl/vec_mem_sequencer_if.sv
// vec_mem_sequencer_if
// Purpose : bundles the dual-port DMem bus between the vector sequencer and
//           the data memory. Port A carries element A reads and result
//           writes, port B carries element B reads only.
// Signals : mem_wea/mem_addra/mem_dina/mem_douta - DMem port A
//           mem_web/mem_addrb/mem_dinb/mem_doutb - DMem port B
// Modports: master - the sequencer (drives addresses, enables, write data)
//           slave  - the memory (returns read data)
interface vec_mem_sequencer_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
);

   logic              mem_wea;
   logic [ADDR_W-1:0] mem_addra;
   logic [DATA_W-1:0] mem_dina;
   logic [DATA_W-1:0] mem_douta;
   logic              mem_web;
   logic [ADDR_W-1:0] mem_addrb;
   logic [DATA_W-1:0] mem_dinb;
   logic [DATA_W-1:0] mem_doutb;

   modport master (
      output mem_wea, mem_addra, mem_dina,
      output mem_web, mem_addrb, mem_dinb,
      input  mem_douta, mem_doutb
   );

   modport slave (
      input  mem_wea, mem_addra, mem_dina,
      input  mem_web, mem_addrb, mem_dinb,
      output mem_douta, mem_doutb
   );

endinterface

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer
// Purpose : runs one memory-to-memory vector operation D[i] = f(A[i], B[i])
//           over the dual-port DMem, three cycles per element
//           (READ -> EXEC -> WRITE), followed by a one-cycle done pulse.
// Ports   : clka          system clock (also clocks the DMem)
//           rst_n         asynchronous active-low reset
//           start         one-cycle request, only looked at in IDLE
//           op            00 add, 01 sub (A-B), 10 and, 11 or
//           src_a/src_b   base addresses of the operand vectors
//           dst           base address of the result vector
//           len           element count, 0..1024
//           busy          high while an operation is in flight
//           done          one-cycle completion pulse
//           mem           DMem bus (vec_mem_sequencer_if.master)
// Options : define VSEQ_SAT_EN to make add/sub saturate as signed
//           two's-complement values instead of wrapping modulo 2^DATA_W.
module vec_mem_sequencer #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 1
) (
   input  logic                clka,
   input  logic                rst_n,
   input  logic                start,
   input  logic [1:0]          op,
   input  logic [ADDR_W-1:0]   src_a,
   input  logic [ADDR_W-1:0]   src_b,
   input  logic [ADDR_W-1:0]   dst,
   input  logic [ADDR_W:0]     len,
   output logic                busy,
   output logic                done,
   vec_mem_sequencer_if.master mem
);

   // The READ -> EXEC spacing assumes the DMem returns data one cycle after
   // the address is presented; any other latency would sample stale data.
   if (RD_LAT != 1) begin : g_rd_lat_unsupported
      $error("vec_mem_sequencer supports RD_LAT == 1 only");
   end

   localparam logic [DATA_W-1:0] MaxPos = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MaxNeg = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WRITE,
      S_DONE
   } state_t;

   state_t              state, state_next;
   logic [1:0]          op_r, op_next;
   logic [ADDR_W-1:0]   src_a_r, src_a_next;
   logic [ADDR_W-1:0]   src_b_r, src_b_next;
   logic [ADDR_W-1:0]   dst_r, dst_next;
   logic [ADDR_W:0]     len_r, len_next;
   logic [ADDR_W-1:0]   i, i_next;
   logic                busy_next, done_next;
   logic                wea_r, wea_next;
   logic [ADDR_W-1:0]   addra_r, addra_next;
   logic [ADDR_W-1:0]   addrb_r, addrb_next;
   logic [DATA_W-1:0]   dina_r, dina_next;
   logic                last_elem;

   // Element ALU. add/sub either wrap or, with VSEQ_SAT_EN, clamp on signed
   // overflow toward the sign of A (overflow can only move away from A's
   // sign, so A's sign tells which rail to clamp to).
   function automatic logic [DATA_W-1:0] alu(
      input logic [1:0]        f,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      logic [DATA_W-1:0] sum;
      logic [DATA_W-1:0] diff;
      logic [DATA_W-1:0] result;
      sum  = a + b;
      diff = a - b;
      case (f)
         2'b00: result = sum;
         2'b01: result = diff;
         2'b10: result = a & b;
         default: result = a | b;
      endcase
`ifdef VSEQ_SAT_EN
      if (f == 2'b00 && a[DATA_W-1] == b[DATA_W-1] && sum[DATA_W-1] != a[DATA_W-1]) begin
         result = a[DATA_W-1] ? MaxNeg : MaxPos;
      end
      if (f == 2'b01 && a[DATA_W-1] != b[DATA_W-1] && diff[DATA_W-1] != a[DATA_W-1]) begin
         result = a[DATA_W-1] ? MaxNeg : MaxPos;
      end
`else
      if (result == MaxPos && MaxNeg == MaxPos) begin
         result = '0;
      end
`endif
      return result;
   endfunction

   assign last_elem = ({1'b0, i} == (len_r - 1'b1));

   // State and every output are registered together. The comb block below
   // decides what the outputs should be in the state being entered, so the
   // memory sees address/enable/data for a state during that very state.
   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         op_r    <= '0;
         src_a_r <= '0;
         src_b_r <= '0;
         dst_r   <= '0;
         len_r   <= '0;
         i       <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wea_r   <= 1'b0;
         addra_r <= '0;
         addrb_r <= '0;
         dina_r  <= '0;
      end else begin
         state   <= state_next;
         op_r    <= op_next;
         src_a_r <= src_a_next;
         src_b_r <= src_b_next;
         dst_r   <= dst_next;
         len_r   <= len_next;
         i       <= i_next;
         busy    <= busy_next;
         done    <= done_next;
         wea_r   <= wea_next;
         addra_r <= addra_next;
         addrb_r <= addrb_next;
         dina_r  <= dina_next;
      end
   end

   // Next-state and next-output logic. Addresses and write data hold by
   // default; write enable, busy and done default low so they only pulse in
   // the states that need them. The ALU result is captured straight into the
   // port A write-data register on the EXEC -> WRITE edge, while the DMem
   // read data for this element is valid. The next element's read addresses
   // are issued on the WRITE -> READ edge, so the current write lands before
   // the following read and overlapping vectors behave element by element.
   always_comb begin
      state_next = state;
      op_next    = op_r;
      src_a_next = src_a_r;
      src_b_next = src_b_r;
      dst_next   = dst_r;
      len_next   = len_r;
      i_next     = i;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      wea_next   = 1'b0;
      addra_next = addra_r;
      addrb_next = addrb_r;
      dina_next  = dina_r;

      case (state)
         S_IDLE: begin
            if (start) begin
               op_next    = op;
               src_a_next = src_a;
               src_b_next = src_b;
               dst_next   = dst;
               len_next   = len;
               i_next     = '0;
               if (len == '0) begin
                  state_next = S_DONE;
                  done_next  = 1'b1;
               end else begin
                  state_next = S_READ;
                  busy_next  = 1'b1;
                  addra_next = src_a;
                  addrb_next = src_b;
               end
            end
         end
         S_READ: begin
            state_next = S_EXEC;
            busy_next  = 1'b1;
         end
         S_EXEC: begin
            state_next = S_WRITE;
            busy_next  = 1'b1;
            wea_next   = 1'b1;
            addra_next = dst_r + i;
            dina_next  = alu(op_r, mem.mem_douta, mem.mem_doutb);
         end
         S_WRITE: begin
            if (last_elem) begin
               state_next = S_DONE;
               done_next  = 1'b1;
            end else begin
               state_next = S_READ;
               busy_next  = 1'b1;
               i_next     = i + 1'b1;
               addra_next = src_a_r + i + 1'b1;
               addrb_next = src_b_r + i + 1'b1;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Port B is read-only for this block.
   assign mem.mem_wea   = wea_r;
   assign mem.mem_addra = addra_r;
   assign mem.mem_dina  = dina_r;
   assign mem.mem_web   = 1'b0;
   assign mem.mem_addrb = addrb_r;
   assign mem.mem_dinb  = '0;

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Sequences one memory-to-memory vector operation over the dual-port DMem (16-bit data, 10-bit address).
- Per element: reads A[i] on port A and B[i] on port B in the same cycle, computes the selected ALU op, and writes the result to D[i] through port A.
- Sits between instruction decode and DMem; owns both DMem ports while busy.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 10, DMem address width.
- RD_LAT, 1, DMem read latency in cycles (fixed 1; other values unsupported).

Ports:
- clka  in  1  system clock (same clock drives DMem clka and clkb).
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  00 add, 01 sub (A-B), 10 and, 11 or.
- src_a  in  ADDR_W  base address of vector A.
- src_b  in  ADDR_W  base address of vector B.
- dst  in  ADDR_W  base address of result vector D.
- len  in  ADDR_W+1  element count, 0..1024.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- mem_wea  out  1  DMem port A write enable.
- mem_addra  out  ADDR_W  DMem port A address.
- mem_dina  out  DATA_W  DMem port A write data.
- mem_douta  in  DATA_W  DMem port A read data.
- mem_web  out  1  DMem port B write enable; constant 0.
- mem_addrb  out  ADDR_W  DMem port B address.
- mem_dinb  out  DATA_W  constant 0.
- mem_doutb  in  DATA_W  DMem port B read data.

Behaviour:
- Clock and reset:
  - One clock, clka. Reset is asynchronous and active-low (rst_n).
  - Reset forces state IDLE and clears index i. busy, done, mem_wea, mem_addra, mem_addrb and mem_dina all reset to 0.
- States: IDLE, READ, EXEC, WRITE, DONE.
- IDLE:
  - On start=1, latch op, src_a, src_b, dst and len, and set i=0.
  - If len==0, go to DONE. Otherwise go to READ.
  - start is ignored in every other state; inputs are not re-sampled while busy.
- READ:
  - mem_addra=src_a+i, mem_addrb=src_b+i, mem_wea=0.
  - Next state EXEC.
- EXEC:
  - mem_douta and mem_doutb are valid (RD_LAT=1).
  - res <= f(op, A, B), registered.
  - Next state WRITE.
- WRITE:
  - mem_wea=1, mem_addra=dst+i, mem_dina=res.
  - If i==len-1, go to DONE. Otherwise i<=i+1 and go to READ.
- DONE:
  - done=1 for exactly one cycle, busy=0.
  - Next state IDLE. A new start is accepted in the following cycle.
- Timing: 3 cycles per element. done asserts 3*len+1 cycles after the start cycle (len=0: 1 cycle).
- Arithmetic:
  - add/sub are modulo 2^16; carry and borrow are discarded.
  - and/or are bitwise.
- Address arithmetic is modulo 2^ADDR_W. Vectors wrap from 1023 to 0 with no error.
- Overlap:
  - The write of element i completes before the read of element i+1.
  - In-place operation (dst==src_a or dst==src_b) gives elementwise-correct results.
  - dst=src_a+1 propagates the updated values forward; this is the defined behaviour.
- Reset mid-operation: returns to IDLE immediately and drops mem_wea. The current element write may or may not have occurred; no done pulse.
- Outputs are registered. In READ and EXEC, mem_wea=0.

Optional Feature:
- Macro VSEQ_SAT_EN.
- Defined: add/sub use signed two's-complement saturation, clamping to 16'h7FFF or 16'h8000 on overflow. and/or are unchanged.
- Undefined: add/sub wrap modulo 2^16.

Test Plan:
- Add, no wrap:
  - Setup: preload A@0x010={1,2,3,4}, B@0x020={10,20,30,40}.
  - Stimulus: start op=00, dst=0x030, len=4.
  - Required: D={11,22,33,44}; done exactly 13 cycles after start; busy high during cycles 1..12.
- Sub, wrap and saturation:
  - Stimulus: A=16'h8000, B=1, len=1.
  - Without VSEQ_SAT_EN: result 16'h7FFF.
  - With VSEQ_SAT_EN: result 16'h8000.
  - Also 16'h7FFF+1 gives 16'h8000 when unsaturated and 16'h7FFF when saturated.
- Address wrap:
  - Stimulus: src_a=0x3FE, src_b=0x100, dst=0x3FF, len=3, op=11.
  - Required: reads A at 0x3FE, 0x3FF, 0x000; writes at 0x3FF, 0x000, 0x001; mem_web never 1.
- len=0 and ignored start:
  - len=0 start: done next cycle, no mem_wea.
  - start pulses while busy during a len=2 op: no effect on the result or cycle count.
- In-place:
  - Stimulus: dst=src_a=0x040, A={5,6}, B={0xFFFF,0x00F0}, op=10.
  - Required: A becomes {5,0}.
- Reset mid-op:
  - Stimulus: assert rst_n=0 asynchronously in EXEC of element 2 of len=4.
  - Required: outputs 0 immediately, no done; a fresh start afterwards completes normally.
